// File: rtl/tetris_input_ctrl_if.sv
// tetris_input_ctrl_if: valid/ready command handshake from the button front end to game_logic.
interface tetris_input_ctrl_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: sync, debounce, DAS/ARR repeat and prioritised valid/ready command output for five buttons.
// Optional: TETRIS_INPUT_STATS_EN builds the saturating coalesced-event counter behind dropped_events.
module tetris_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DAS_CYCLES      = 4000000,
  parameter int ARR_CYCLES      = 1250000
) (
  input  logic                       clk_25MHz,
  input  logic                       game_reset,
  input  logic [4:0]                 btn_raw,
  tetris_input_ctrl_if.master        cmd_if,
  output logic [15:0]                dropped_events
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPW = $clog2((DAS_CYCLES > ARR_CYCLES ? DAS_CYCLES : ARR_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} das_t;
  logic [4:0] sync1_q, sync2_q, stable_q, stable_d, pending_q, pending_d;
  logic [4:0] diff, flip, press, fall, set, clr;
  logic [DBW-1:0] db_cnt_q [5];
  logic [DBW-1:0] db_cnt_d [5];
  das_t das_q [3];
  das_t das_d [3];
  logic [RPW-1:0] rp_cnt_q [3];
  logic [RPW-1:0] rp_cnt_d [3];
  logic [2:0] rep, kill;
  logic cmd_valid_q, cmd_valid_d, load;
  logic [2:0] cmd_q, cmd_d;
  assign diff = sync2_q ^ stable_q;
  always_comb begin
    flip = '0;
    for (int i = 0; i < 5; i++) begin
      flip[i] = diff[i] && (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1));
      db_cnt_d[i] = (diff[i] && !flip[i]) ? db_cnt_q[i] + 1'b1 : '0;
    end
    stable_d = stable_q ^ flip;
    press = flip & ~stable_q;
    fall = flip & stable_q;
  end
  // a fresh LEFT press cancels RIGHT's repeat and vice versa; a button's own press wins over the cancel
  assign kill = {1'b0, press[0], press[1]};
  always_comb begin
    rep = '0;
    for (int i = 0; i < 3; i++) begin
      das_d[i] = das_q[i];
      if (fall[i]) das_d[i] = IDLE;
      else if (press[i]) das_d[i] = DELAY;
      else if (kill[i]) das_d[i] = IDLE;
      else if (das_q[i] == DELAY && rp_cnt_q[i] == RPW'(DAS_CYCLES - 1)) begin
        rep[i] = 1'b1;
        das_d[i] = REPEAT;
      end else if (das_q[i] == REPEAT && rp_cnt_q[i] == RPW'(ARR_CYCLES - 1)) rep[i] = 1'b1;
      rp_cnt_d[i] = (das_d[i] != das_q[i] || rep[i] || das_q[i] == IDLE) ? '0 : rp_cnt_q[i] + 1'b1;
    end
  end
  assign load = !cmd_valid_q || cmd_if.cmd_ready;
  always_comb begin
    clr = '0;
    cmd_valid_d = load ? |pending_q : cmd_valid_q;
    cmd_d = !load ? cmd_q :
            pending_q[4] ? 3'd4 : pending_q[3] ? 3'd3 : pending_q[0] ? 3'd0 :
            pending_q[1] ? 3'd1 : pending_q[2] ? 3'd2 : cmd_q;
    if (load) clr[cmd_d] = |pending_q;
    set = press | {2'b00, rep};
    pending_d = (pending_q & ~clr) | set;
  end
  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd = cmd_q;
  always_ff @(posedge clk_25MHz) begin
    if (game_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stable_q <= '0;
      pending_q <= '0;
      db_cnt_q <= '{default: '0};
      das_q <= '{default: IDLE};
      rp_cnt_q <= '{default: '0};
      cmd_valid_q <= 1'b0;
      cmd_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      pending_q <= pending_d;
      db_cnt_q <= db_cnt_d;
      das_q <= das_d;
      rp_cnt_q <= rp_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q <= cmd_d;
    end
  end
`ifdef TETRIS_INPUT_STATS_EN
  logic [4:0] coal;
  logic [16:0] drop_sum;
  logic [15:0] drop_q, drop_d;
  always_comb begin
    coal = set & pending_q & ~clr;
    drop_sum = {1'b0, drop_q} + 17'($countones(coal));
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  always_ff @(posedge clk_25MHz) begin
    if (game_reset) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign dropped_events = drop_q;
`else
  assign dropped_events = '0;
`endif
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb_tetris_input_ctrl: directed scenarios plus random button/ready/reset traffic against a behavioural model.
module tb_tetris_input_ctrl;
  localparam int DB = 4, DAS = 10, ARR = 3;
`ifdef TETRIS_INPUT_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] btn = '0;
  logic [15:0] drops;
  tetris_input_ctrl_if bus();
  tetris_input_ctrl #(.DEBOUNCE_CYCLES(DB), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR)) dut (
    .clk_25MHz(clk), .game_reset(rst), .btn_raw(btn), .cmd_if(bus), .dropped_events(drops));
  always #5 clk = ~clk;
  int total = 0, bad = 0, edge_n = 0, t0 = 0;
  int prio[5] = '{4, 3, 0, 1, 2};
  logic [4:0] m_s1, m_s2, m_stab, m_pend;
  int m_run[5], m_age[3];
  bit m_act[3];
  bit m_v;
  int m_cmd, m_drop;
  int mlog_e[$], mlog_c[$];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // spec-level model: debounce as a run length, DAS/ARR as arithmetic on time since press
  task automatic model();
    logic [4:0] flip, press, fall, set, clr;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_pend = '0;
      m_run = '{default: 0}; m_age = '{default: 0}; m_act = '{default: 0};
      m_v = 0; m_cmd = 0; m_drop = 0;
      return;
    end
    flip = '0;
    for (int i = 0; i < 5; i++) begin
      m_run[i] = (m_s2[i] != m_stab[i]) ? m_run[i] + 1 : 0;
      if (m_run[i] == DB) begin flip[i] = 1'b1; m_run[i] = 0; end
    end
    press = flip & ~m_stab;
    fall = flip & m_stab;
    set = press;
    for (int i = 0; i < 3; i++) begin
      if (fall[i]) m_act[i] = 0;
      else if (press[i]) begin m_act[i] = 1; m_age[i] = 0; end
      else if ((i == 0 && press[1]) || (i == 1 && press[0])) m_act[i] = 0;
      else if (m_act[i]) begin
        m_age[i]++;
        if (m_age[i] >= DAS && (m_age[i] - DAS) % ARR == 0) set[i] = 1'b1;
      end
    end
    clr = '0;
    if (!m_v || bus.cmd_ready) begin
      m_v = 0;
      for (int k = 0; k < 5; k++)
        if (!m_v && m_pend[prio[k]]) begin m_v = 1; m_cmd = prio[k]; clr[prio[k]] = 1'b1; end
    end
    for (int i = 0; i < 5; i++)
      if (set[i] && m_pend[i] && !clr[i] && m_drop < 65535) m_drop++;
    m_pend = (m_pend & ~clr) | set;
    m_stab = m_stab ^ flip;
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic step();
    if (m_v && bus.cmd_ready) begin mlog_e.push_back(edge_n - t0); mlog_c.push_back(m_cmd); end
    @(posedge clk);
    edge_n++;
    model();
    #1;
    chk("valid", int'(bus.cmd_valid), int'(m_v));
    if (m_v) chk("cmd", int'(bus.cmd), m_cmd);
    chk("drops", int'(drops), STATS ? m_drop : 0);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mlog_e.delete();
    mlog_c.delete();
    t0 = edge_n;
  endtask

  task automatic chk_log(string nm, int idx, int e, int c);
    if (idx < mlog_e.size()) begin
      chk(nm, mlog_e[idx], e);
      chk(nm, mlog_c[idx], c);
    end else chk(nm, -1, e);
  endtask

  initial begin
    bus.cmd_ready = 1'b1;
    do_reset();
    chk("rst_valid", int'(bus.cmd_valid), 0);
    chk("rst_drops", int'(drops), 0);
    // ROTATE held: one command at edge 7, nothing on release
    btn = 5'b01000; run(30); btn = '0; run(20);
    chk("rot_count", mlog_e.size(), 1);
    chk_log("rot_first", 0, 7, 3);
    // HARD_DROP glitch then a real pulse
    do_reset();
    btn = 5'b10000; run(3); btn = '0; run(15);
    chk("glitch_count", mlog_e.size(), 0);
    t0 = edge_n; mlog_e.delete(); mlog_c.delete();
    btn = 5'b10000; run(5); btn = '0; run(15);
    chk("pulse_count", mlog_e.size(), 1);
    chk_log("pulse_first", 0, 7, 4);
    // LEFT held 40: 7, 17, then every 3 until stable falls
    do_reset();
    btn = 5'b00001; run(40); btn = '0; run(20);
    chk("left_count", mlog_e.size(), 11);
    chk_log("left_0", 0, 7, 0);
    chk_log("left_1", 1, 17, 0);
    chk_log("left_2", 2, 20, 0);
    chk_log("left_3", 3, 23, 0);
    chk_log("left_last", 10, 44, 0);
    // blocked output: HARD_DROP wins over LEFT and holds
    do_reset();
    bus.cmd_ready = 1'b0;
    btn = 5'b10001;
    for (int k = 1; k <= 27; k++) begin
      if (k == 10) btn = '0;
      step();
      if (k >= 7) begin chk("hold_v", int'(m_v), 1); chk("hold_cmd", m_cmd, 4); end
    end
    bus.cmd_ready = 1'b1;
    step();
    chk("after_v", int'(m_v), 1);
    chk("after_cmd", m_cmd, 0);
    step();
    chk("after_idle", int'(m_v), 0);
    // three ROTATE presses into a blocked output: third one coalesces
    do_reset();
    bus.cmd_ready = 1'b0;
    repeat (3) begin btn = 5'b01000; run(6); btn = '0; run(6); end
    run(4);
    chk("coal_model", m_drop, 1);
    chk("coal_drops", int'(drops), STATS);
    mlog_e.delete(); mlog_c.delete();
    bus.cmd_ready = 1'b1;
    run(10);
    chk("coal_count", mlog_e.size(), 2);
    chk_log("coal_0", 0, mlog_e.size() > 0 ? mlog_e[0] : -2, 3);
    chk_log("coal_1", 1, mlog_e.size() > 1 ? mlog_e[1] : -2, 3);
    // reset during RIGHT repeat
    do_reset();
    btn = 5'b00010; run(20);
    chk("rr_pre_v", int'(m_v), 1);
    do_reset();
    chk("rr_rst_v", int'(bus.cmd_valid), 0);
    chk("rr_rst_drops", int'(drops), 0);
    run(10);
    chk_log("rr_first", 0, 7, 1);
    // random traffic with bounce, back-pressure and occasional reset
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, 4)] ^= 1'b1;
      bus.cmd_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
